fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end: owns the PC, issues in-order word requests to the
//  instruction cache, buffers returned instructions in an FQ_DEPTH queue and hands them to decode
//  over a valid/ready handshake. Supports multiple outstanding cache requests and branch redirect
//  with stale-response squash. Sits between the pipeline redirect source and Set_Associative_Cache.
// PARAMETERS
//  ADDRESS_WIDTH      64    PC / request address width
//  INSTRUCTION_WIDTH  32    instruction word width
//  FQ_DEPTH           4     instruction queue entries (power of 2, >=2)
//  MAX_OUTSTANDING    2     max cache requests in flight (1..FQ_DEPTH)
//  RESET_PC           0     first fetch address after reset
// PORTS
//  clk                 in   1    clock
//  reset               in   1    asynchronous, active-low reset
//  in_redirect_valid   in   1    redirect PC this cycle (branch taken / flush)
//  in_redirect_target  in   AW   redirect target
//  icache_req_valid    out  1    request valid
//  icache_req_addr     out  AW   request address (word aligned)
//  icache_req_ready    in   1    cache accepts request
//  icache_resp_valid   in   1    response valid (in request order, always accepted)
//  icache_resp_bits    in   IW   response instruction
//  out_inst_valid      out  1    queue head valid
//  out_inst_bits       out  IW   queue head instruction
//  out_inst_pc         out  AW   queue head PC
//  in_inst_ready       in   1    decode accepts head
//  out_halted          out  1    fetch stopped (FAULT state)
//  out_perf_req        out  32   requests issued (FETCH_PERF_CNT_EN)
//  out_perf_squash     out  32   responses squashed (FETCH_PERF_CNT_EN)
//  out_perf_stall      out  32   cycles valid head not taken (FETCH_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset (reset==0, async): pc=RESET_PC, queue empty, outstanding=0, squash=0, state=RUN; all outputs 0.
//  - Request issue: icache_req_valid=1 iff state==RUN && !in_redirect_valid && outstanding<MAX_OUTSTANDING
//    && (queue_count+outstanding)<FQ_DEPTH (slot reserved per request; response never overflows queue).
//    icache_req_addr=pc. On valid&&ready: pc<=pc+4 (mod 2^AW), outstanding++ ; req carries its PC in a
//    MAX_OUTSTANDING-deep in-flight PC FIFO.
//  - Response: if squash>0: drop, squash--, outstanding--. Else push {pc,bits} into queue, outstanding--.
//    Response with bits==0 (illegal all-zero word): not pushed; state<=FAULT.
//  - Dequeue: out_inst_valid=!empty; pop when valid&&in_inst_ready. Push and pop same cycle legal at full/empty.
//    Outputs are queue head registers; enqueue-to-visible latency 1 cycle, request-to-head >=2 cycles.
//  - Redirect (in_redirect_valid=1): pc<=target; queue flushed (same-cycle pop ignored); squash<=
//    outstanding after this cycle's response/request effects; no request issued this cycle; state<=RUN
//    unless target[1:0]!=0, then state<=FAULT. Redirect has priority over response push and FAULT entry.
//  - FSM: RUN -> FAULT on zero-word response or misaligned redirect; FAULT -> RUN only on aligned redirect.
//    In FAULT: no requests, out_halted=1, queue still drains to decode, in-flight responses discarded.
//  - Reset mid-operation: everything returns to reset values immediately; in-flight cache responses
//    arriving after reset release are NOT tracked (cache is reset by the same signal).
//  - Counters wrap at 2^32.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: out_perf_req/squash/stall count (stall = out_inst_valid&&!in_inst_ready),
//  reset to 0. Undefined: counters not built, the three ports tied to 0.
// STRUCTURE
//  fetch_pkg: fetch_state_e {RUN, FAULT}; fq_entry_t struct {pc, bits}; constant INST_BYTES=4.
//  Sub-module fetch_queue: FQ_DEPTH circular FIFO of fq_entry_t with push/pop/flush/count, wrap-around
//  pointers with extra MSB for full/empty. Top holds PC, outstanding/squash counters, FSM, perf counters.
// TESTING
//  1 Reset release, cache always ready, resp 1 cycle later with 0x00000013 -> head pc 0,4,8.. bits 0x13 in order.
//  2 in_inst_ready=0 with FQ_DEPTH=4 -> exactly 4 entries queued, req_valid drops, none lost; resume in order.
//  3 Redirect to 0x100 with 2 requests in flight -> 2 responses squashed, queue empty, next head pc 0x100.
//  4 Response 0x00000000 at pc 0x8 -> out_halted=1, no further requests, earlier entries still delivered;
//    redirect to 0x40 -> out_halted=0, fetch resumes at 0x40.
//  5 Redirect to 0x102 -> FAULT, no request; same-cycle redirect + response -> response squashed.
//  6 Assert reset mid-stream, async -> outputs 0 within same cycle, pc=RESET_PC; perf counters 0
//    with FETCH_PERF_CNT_EN, counts match scoreboard after scenario 3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned InstBytes   = 4;
  localparam int unsigned FqAddrWidth = 64;
  localparam int unsigned FqInstWidth = 32;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFault = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FqAddrWidth-1:0] pc;
    logic [FqInstWidth-1:0] bits;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue of fq_entry_t; pointers carry an extra wrap bit for full/empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  fq_entry_t              entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fq_entry_t              head_o,
  output logic                   valid_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  fq_entry_t     mem_q [Depth];
  logic          empty, full, do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // A flush wins over both push and pop in the same cycle.
  assign do_pop  = pop_i && !empty && !flush_i;
  assign do_push = push_i && !flush_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= entry_i;
    end
  end

  assign valid_o = !empty;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC, in-order icache requests, squash on redirect, decode-side queue.
// Define FETCH_PERF_CNT_EN to build the request/squash/stall performance counters.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH     = 64,
  parameter int unsigned              INSTRUCTION_WIDTH = 32,
  parameter int unsigned              FQ_DEPTH          = 4,
  parameter int unsigned              MAX_OUTSTANDING   = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     in_redirect_target,
  output logic                         icache_req_valid,
  output logic [ADDRESS_WIDTH-1:0]     icache_req_addr,
  input  logic                         icache_req_ready,
  input  logic                         icache_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] icache_resp_bits,
  output logic                         out_inst_valid,
  output logic [INSTRUCTION_WIDTH-1:0] out_inst_bits,
  output logic [ADDRESS_WIDTH-1:0]     out_inst_pc,
  input  logic                         in_inst_ready,
  output logic                         out_halted,
  output logic [31:0]                  out_perf_req,
  output logic [31:0]                  out_perf_squash,
  output logic [31:0]                  out_perf_stall
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IdxW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [OutW-1:0]          outstanding_q, outstanding_d;
  logic [OutW-1:0]          squash_q, squash_d;

  logic [ADDRESS_WIDTH-1:0] infl_pc_q [MAX_OUTSTANDING];
  logic [IdxW-1:0]          infl_wr_q, infl_rd_q;
  logic [ADDRESS_WIDTH-1:0] resp_pc;

  logic                     req_fire, resp_take, resp_squash, resp_live, resp_zero;
  logic                     fq_push, fq_pop;
  fq_entry_t                fq_in, fq_head;
  logic [CntW-1:0]          fq_count;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (32'(idx) == MAX_OUTSTANDING - 1) ? '0 : idx + IdxW'(1);
  endfunction

  // Queue slots are reserved per request, so a live response can always be pushed.
  // The reset term keeps the request strobe low while reset is held.
  assign icache_req_valid = reset && (state_q == StRun) && !in_redirect_valid &&
                            (32'(outstanding_q) < MAX_OUTSTANDING) &&
                            ((32'(fq_count) + 32'(outstanding_q)) < FQ_DEPTH);
  assign icache_req_addr  = pc_q;
  assign req_fire         = icache_req_valid && icache_req_ready;

  assign resp_take   = icache_resp_valid && (outstanding_q != '0);
  assign resp_squash = resp_take && (in_redirect_valid || (squash_q != '0));
  assign resp_live   = resp_take && !resp_squash && (state_q == StRun);
  assign resp_zero   = resp_live && (icache_resp_bits == '0);
  assign resp_pc     = infl_pc_q[infl_rd_q];

  assign fq_push    = resp_live && !resp_zero;
  assign fq_pop     = out_inst_valid && in_inst_ready;
  assign fq_in.pc   = FqAddrWidth'(resp_pc);
  assign fq_in.bits = FqInstWidth'(icache_resp_bits);

  assign outstanding_d = outstanding_q + OutW'(req_fire) - OutW'(resp_take);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    if (resp_take && (squash_q != '0)) squash_d = squash_q - OutW'(1);
    if (resp_zero) state_d = StFault;
    if (req_fire) pc_d = pc_q + ADDRESS_WIDTH'(InstBytes);
    // Everything still in flight after this cycle belongs to the old path.
    if (in_redirect_valid) begin
      pc_d     = in_redirect_target;
      squash_d = outstanding_d;
      state_d  = (in_redirect_target[1:0] != 2'b00) ? StFault : StRun;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      squash_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) infl_pc_q[i] <= '0;
      infl_wr_q <= '0;
      infl_rd_q <= '0;
    end else begin
      if (req_fire) begin
        infl_pc_q[infl_wr_q] <= pc_q;
        infl_wr_q            <= next_idx(infl_wr_q);
      end
      if (resp_take) infl_rd_q <= next_idx(infl_rd_q);
    end
  end

  fetch_queue #(
    .Depth (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fq_push),
    .entry_i (fq_in),
    .pop_i   (fq_pop),
    .flush_i (in_redirect_valid),
    .head_o  (fq_head),
    .valid_o (out_inst_valid),
    .count_o (fq_count)
  );

  assign out_inst_bits = fq_head.bits[INSTRUCTION_WIDTH-1:0];
  assign out_inst_pc   = fq_head.pc[ADDRESS_WIDTH-1:0];
  assign out_halted    = (state_q == StFault);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_req_q, perf_squash_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_q    <= '0;
      perf_squash_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (req_fire)                        perf_req_q    <= perf_req_q + 32'd1;
      if (resp_squash)                     perf_squash_q <= perf_squash_q + 32'd1;
      if (out_inst_valid && !in_inst_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign out_perf_req    = perf_req_q;
  assign out_perf_squash = perf_squash_q;
  assign out_perf_stall  = perf_stall_q;
`else
  assign out_perf_req    = '0;
  assign out_perf_squash = '0;
  assign out_perf_stall  = '0;
`endif

endmodule
